color_freq_scanner: RTL

Parametrised colour-sensor front end for a TCS3200-style light-to-frequency sensor. It cycles the photodiode filter selects over red, blue, green and, optionally, clear. Each channel gets a programmable settle window and a programmable gate window; rising edges of the sensor output are counted and scaled into per-channel frequency registers. After each full frame the block classifies the dominant colour and emits a one-cycle result strobe for the motor/display logic downstream.

---
 rtl/color_freq_scanner.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/color_freq_scanner.sv
// color_freq_scanner: TCS3200 colour-sensor scanner with per-channel frequency capture and dominant-colour classification
module color_freq_scanner #(
    parameter int GATE_CYCLES   = 12_500_000,
    parameter int SETTLE_CYCLES = 1000,
    parameter int CNT_W         = 25,
    parameter int SCALE_SHIFT   = 3,
    parameter int NUM_CH        = 4,
    parameter int MIN_LEVEL     = 1800,
    parameter int DARK_LEVEL    = 500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             freq_in,
    input  logic [1:0]       scale_sel,
    output logic             s0,
    output logic             s1,
    output logic             s2,
    output logic             s3,
    output logic             oe_n,
    output logic [CNT_W-1:0] freq_red,
    output logic [CNT_W-1:0] freq_blue,
    output logic [CNT_W-1:0] freq_green,
    output logic [CNT_W-1:0] freq_clear,
    output logic [3:0]       sat_flags,
    output logic [2:0]       color_code,
    output logic             result_valid,
    output logic [7:0]       frame_cnt,
    output logic             busy
);

    localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam int WW   = CNT_W + SCALE_SHIFT;
    localparam logic [TW-1:0]    S_END  = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0]    G_END  = TW'(GATE_CYCLES - 1);
    localparam logic [1:0]       LAST   = 2'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] MIN_L  = CNT_W'(MIN_LEVEL);
    localparam logic [CNT_W-1:0] DARK_L = CNT_W'(DARK_LEVEL);

    typedef enum logic [2:0] {IDLE, SETTLE, GATE, STORE, CLASSIFY} state_t;

    state_t           state, state_nx;
    logic [TW-1:0]    tmr;
    logic [1:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic             s_meta, s_sync, s_prev, rise;
    logic [CNT_W-1:0] freq [4];
    logic [WW-1:0]    wide;
    logic             ovf;
    logic [CNT_W-1:0] scaled;
    logic [2:0]       cls;
    logic [CNT_W-1:0] r, g, b;

    assign rise       = s_sync & ~s_prev;
    assign busy       = (state != IDLE);
    assign freq_red   = freq[0];
    assign freq_blue  = freq[1];
    assign freq_green = freq[2];
    assign freq_clear = freq[3];
    assign r          = freq[0];
    assign b          = freq[1];
    assign g          = freq[2];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state: dropping en aborts a channel but never a classification
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = en ? SETTLE : IDLE;
            SETTLE:   state_nx = !en ? IDLE : (tmr == S_END) ? GATE : SETTLE;
            GATE:     state_nx = !en ? IDLE : (tmr == G_END) ? STORE : GATE;
            STORE:    state_nx = !en ? IDLE : (idx == LAST) ? CLASSIFY : SETTLE;
            CLASSIFY: state_nx = en ? SETTLE : IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Filter select for the active channel; red while idle
    always_comb begin
        {s2, s3} = 2'b00;
        {s2, s3} = (state == IDLE) ? 2'b00 : (idx == 2'd1) ? 2'b01 :
                   (idx == 2'd2) ? 2'b11 : (idx == 2'd3) ? 2'b10 : 2'b00;
    end

    // Scale the gate count, saturating if any bit would be shifted out
    always_comb begin
        wide   = WW'(cnt) << SCALE_SHIFT;
        ovf    = (wide >> CNT_W) != '0;
        scaled = ovf ? '1 : wide[CNT_W-1:0];
    end

    // Dominant-colour decision; strict comparisons make any tie unknown
    always_comb begin
        cls = 3'd0;
        cls = (r < DARK_L && g < DARK_L && b < DARK_L) ? 3'd4 :
              (r > g && r > b && r >= MIN_L) ? 3'd1 :
              (g > r && g > b && g >= MIN_L) ? 3'd2 :
              (b > r && b > g && b >= MIN_L) ? 3'd3 : 3'd0;
    end

    // Synchroniser, sequencing counters, channel registers and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_meta       <= 1'b0;
            s_sync       <= 1'b0;
            s_prev       <= 1'b0;
            tmr          <= '0;
            idx          <= 2'd0;
            cnt          <= '0;
            for (int i = 0; i < 4; i++) freq[i] <= '0;
            sat_flags    <= 4'd0;
            color_code   <= 3'd0;
            result_valid <= 1'b0;
            frame_cnt    <= 8'd0;
            s0           <= 1'b0;
            s1           <= 1'b0;
            oe_n         <= 1'b1;
        end else begin
            s_meta       <= freq_in;
            s_sync       <= s_meta;
            s_prev       <= s_sync;
            tmr          <= (state_nx != state) ? '0 : tmr + TW'(1);
            idx          <= (state == STORE && state_nx == SETTLE) ? idx + 2'd1 :
                            (state == IDLE || state == CLASSIFY || state_nx == IDLE) ? 2'd0 : idx;
            cnt          <= (state == SETTLE) ? '0 :
                            (state == GATE && rise && cnt != '1) ? cnt + CNT_W'(1) : cnt;
            if (state == STORE && en) begin
                freq[idx]      <= scaled;
                sat_flags[idx] <= ovf | (&cnt);
            end
            if (state == CLASSIFY) begin
                color_code <= cls;
                frame_cnt  <= frame_cnt + 8'd1;
            end
            result_valid <= (state == CLASSIFY);
            s0           <= scale_sel[0];
            s1           <= scale_sel[1];
            oe_n         <= ~en;
        end
    end

endmodule
